dds_serial_loader: RTL and testbench

Serial programming engine for the three AD9850-class DDS chips of the impedance analyzer's excitation and reference path. It sits directly downstream of the DDS power-down/reset pulse stage. Once the chips are out of power-down, it shifts a 40-bit frequency/phase word into each chip in parallel over a shared W_CLK and per-chip DATA lines. It then pulses FQ_UD so all three chips update simultaneously.

---
 rtl/dds_pkg.sv | 21 ++
 rtl/dds_word_pack.sv | 18 +
 rtl/dds_serial_loader.sv | 156 +++++++++++++++
 tb/tb_dds_serial_loader.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/dds_pkg.sv
// Shared definitions for the DDS serial loader: word layout and FSM encoding.
package dds_pkg;

    localparam int unsigned DDS_WORD_W = 40;
    localparam int unsigned FTW_W      = 32;
    localparam int unsigned PHASE_W    = 5;

    localparam int unsigned FTW_LSB    = 0;
    localparam int unsigned CTRL_LSB   = 32;
    localparam int unsigned PD_BIT     = 34;
    localparam int unsigned PHASE_LSB  = 35;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_CLKHI,
        ST_FQUD,
        ST_FIN
    } dds_state_e;

endpackage

// File: rtl/dds_word_pack.sv
// Combinational packer: FTW and phase into the 40-bit AD9850 serial word.
module dds_word_pack
    import dds_pkg::*;
(
    input  logic [FTW_W-1:0]      ftw,
    input  logic [PHASE_W-1:0]    phase,
    output logic [DDS_WORD_W-1:0] word
);

    always_comb begin
        word                      = '0;
        word[FTW_LSB +: FTW_W]    = ftw;
        word[CTRL_LSB +: 2]       = 2'b00;
        word[PD_BIT]              = 1'b0;
        word[PHASE_LSB +: PHASE_W] = phase;
    end

endmodule

// File: rtl/dds_serial_loader.sv
// Loads three AD9850-class DDS chips in parallel over shared W_CLK, then pulses FQ_UD.
module dds_serial_loader
    import dds_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               start,
    input  logic               i_pwr_down,
    input  logic [FTW_W-1:0]   ftw1,
    input  logic [FTW_W-1:0]   ftw2,
    input  logic [FTW_W-1:0]   ftw3,
    input  logic [PHASE_W-1:0] phase1,
    input  logic [PHASE_W-1:0] phase2,
    input  logic [PHASE_W-1:0] phase3,
    output logic               busy,
    output logic               done,
    output logic               abort,
    output logic               o_wclk,
    output logic               o_fqud,
    output logic               o_data1,
    output logic               o_data2,
    output logic               o_data3
);

    localparam int unsigned     DIV_W    = $clog2(CLK_DIV + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    dds_state_e state, state_n;

    logic [DIV_W-1:0]      div_cnt;
    logic [5:0]            bit_cnt;
    logic [DDS_WORD_W-1:0] sreg1, sreg2, sreg3;
    logic [DDS_WORD_W-1:0] word1, word2, word3;

    logic div_end, load, shift, kill;
    logic data1_n, data2_n, data3_n;

    dds_word_pack u_pack1 (.ftw(ftw1), .phase(phase1), .word(word1));
    dds_word_pack u_pack2 (.ftw(ftw2), .phase(phase2), .word(word2));
    dds_word_pack u_pack3 (.ftw(ftw3), .phase(phase3), .word(word3));

    always_comb begin
        state_n = state;
        load    = 1'b0;
        shift   = 1'b0;
        div_end = (div_cnt == DIV_LAST);
        kill    = (state != ST_IDLE) && i_pwr_down;

        unique case (state)
            ST_IDLE: begin
                if (start && !i_pwr_down) begin
                    state_n = ST_SETUP;
                    load    = 1'b1;
                end
            end
            ST_SETUP: begin
                if (div_end) state_n = ST_CLKHI;
            end
            ST_CLKHI: begin
                if (div_end) begin
                    if (bit_cnt == 6'd39) begin
                        state_n = ST_FQUD;
                    end else begin
                        state_n = ST_SETUP;
                        shift   = 1'b1;
                    end
                end
            end
            ST_FQUD: begin
                if (div_end) state_n = ST_FIN;
            end
            ST_FIN: begin
                state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase

        if (kill) begin
            state_n = ST_IDLE;
            load    = 1'b0;
            shift   = 1'b0;
        end
    end

    // Outputs are registered from next-state values so they line up with the state change.
    always_comb begin
        data1_n = 1'b0;
        data2_n = 1'b0;
        data3_n = 1'b0;
        if (state_n == ST_SETUP || state_n == ST_CLKHI) begin
            if (load) begin
                data1_n = word1[0];
                data2_n = word2[0];
                data3_n = word3[0];
            end else if (shift) begin
                data1_n = sreg1[1];
                data2_n = sreg2[1];
                data3_n = sreg3[1];
            end else begin
                data1_n = sreg1[0];
                data2_n = sreg2[0];
                data3_n = sreg3[0];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= ST_IDLE;
            div_cnt <= '0;
            bit_cnt <= '0;
            sreg1   <= '0;
            sreg2   <= '0;
            sreg3   <= '0;
        end else begin
            state   <= state_n;
            div_cnt <= (state_n != state || state_n == ST_IDLE) ? '0 : div_cnt + 1'b1;
            if (load) begin
                bit_cnt <= '0;
                sreg1   <= word1;
                sreg2   <= word2;
                sreg3   <= word3;
            end else if (shift) begin
                bit_cnt <= bit_cnt + 6'd1;
                sreg1   <= {1'b0, sreg1[DDS_WORD_W-1:1]};
                sreg2   <= {1'b0, sreg2[DDS_WORD_W-1:1]};
                sreg3   <= {1'b0, sreg3[DDS_WORD_W-1:1]};
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            busy    <= 1'b0;
            done    <= 1'b0;
            abort   <= 1'b0;
            o_wclk  <= 1'b0;
            o_fqud  <= 1'b0;
            o_data1 <= 1'b0;
            o_data2 <= 1'b0;
            o_data3 <= 1'b0;
        end else begin
            busy    <= (state_n == ST_SETUP) || (state_n == ST_CLKHI) || (state_n == ST_FQUD);
            done    <= (state_n == ST_FIN);
            abort   <= kill;
            o_wclk  <= (state_n == ST_CLKHI);
            o_fqud  <= (state_n == ST_FQUD);
            o_data1 <= data1_n;
            o_data2 <= data2_n;
            o_data3 <= data3_n;
        end
    end

endmodule

// File: tb/tb_dds_serial_loader.sv
// Directed bench for dds_serial_loader at CLK_DIV=4 plus a CLK_DIV=1 instance.
module tb_dds_serial_loader;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic        i_pwr_down = 1'b0;
    logic [31:0] ftw1 = '0, ftw2 = '0, ftw3 = '0;
    logic [4:0]  phase1 = '0, phase2 = '0, phase3 = '0;

    logic busy, done, abort, o_wclk, o_fqud, o_data1, o_data2, o_data3;
    logic busy_f, done_f, abort_f, wclk_f, fqud_f, d1_f, d2_f, d3_f;

    int n_checks = 0;
    int n_fail   = 0;

    logic [39:0] cap1, cap2, cap3;
    int wrise, fq_first, fq_last, done_n, done_cnt, abort_cnt, glitch;

    always #5 clk = ~clk;

    dds_serial_loader #(.CLK_DIV(4)) u_dut (
        .clk(clk), .rstn(rstn), .start(start), .i_pwr_down(i_pwr_down),
        .ftw1(ftw1), .ftw2(ftw2), .ftw3(ftw3),
        .phase1(phase1), .phase2(phase2), .phase3(phase3),
        .busy(busy), .done(done), .abort(abort),
        .o_wclk(o_wclk), .o_fqud(o_fqud),
        .o_data1(o_data1), .o_data2(o_data2), .o_data3(o_data3)
    );

    dds_serial_loader #(.CLK_DIV(1)) u_dut_fast (
        .clk(clk), .rstn(rstn), .start(start), .i_pwr_down(i_pwr_down),
        .ftw1(ftw1), .ftw2(ftw2), .ftw3(ftw3),
        .phase1(phase1), .phase2(phase2), .phase3(phase3),
        .busy(busy_f), .done(done_f), .abort(abort_f),
        .o_wclk(wclk_f), .o_fqud(fqud_f),
        .o_data1(d1_f), .o_data2(d2_f), .o_data3(d3_f)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench at the first observation after the start edge (n=1).
    task automatic start_load();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic monitor_load(input int ncyc, input int restart_at);
        logic       pw;
        logic [2:0] pdat;
        cap1 = '0; cap2 = '0; cap3 = '0;
        wrise = 0; fq_first = 0; fq_last = 0; done_n = 0; done_cnt = 0;
        abort_cnt = 0; glitch = 0;
        pw = 1'b0;
        pdat = 3'b000;
        for (int n = 1; n <= ncyc; n++) begin
            if (o_wclk && !pw) begin
                wrise++;
                cap1 = {o_data1, cap1[39:1]};
                cap2 = {o_data2, cap2[39:1]};
                cap3 = {o_data3, cap3[39:1]};
            end
            if (n > 1 && {o_data1, o_data2, o_data3} != pdat && !(pw && !o_wclk)) glitch++;
            if (o_fqud) begin
                if (fq_first == 0) fq_first = n;
                fq_last = n;
            end
            if (done) begin
                done_cnt++;
                if (done_n == 0) done_n = n;
            end
            if (abort) abort_cnt++;
            pw = o_wclk;
            pdat = {o_data1, o_data2, o_data3};
            if (n == restart_at) begin
                start = 1'b1;
                ftw1 = 32'hFFFF_FFFF; ftw2 = 32'h1234_5678; ftw3 = 32'hDEAD_BEEF;
                phase1 = 5'h0A; phase2 = 5'h00; phase3 = 5'h15;
            end else if (n == restart_at + 1) begin
                start = 1'b0;
            end
            tick();
        end
    endtask

    task automatic set_words();
        ftw1 = 32'h0000_0001; phase1 = 5'h00;
        ftw2 = 32'hA5A5_A5A5; phase2 = 5'h1F;
        ftw3 = 32'h0000_0000; phase3 = 5'h00;
    endtask

    initial begin : main
        int found;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {busy, done, abort, o_wclk, o_fqud, o_data1, o_data2, o_data3}, 0);
        @(negedge clk);
        rstn = 1'b1;
        tick();

        // Full load with a second start mid-load that must be ignored.
        set_words();
        start_load();
        check("busy_at_k1", busy, 1);
        check("data_bit0", {o_data1, o_data2, o_data3}, 3'b110);
        monitor_load(330, 50);
        check("cap_data1", cap1, 40'h00_0000_0001);
        check("cap_data2", cap2, 40'hF8_A5A5_A5A5);
        check("cap_data3", cap3, 40'h00_0000_0000);
        check("pd_bit_ch2", cap2[34], 0);
        check("wclk_rises", wrise, 40);
        check("fqud_first", fq_first, 321);
        check("fqud_last", fq_last, 324);
        check("done_cycle", done_n, 325);
        check("done_count", done_cnt, 1);
        check("data_stable", glitch, 0);
        check("busy_after", busy, 0);

        // Abort by power-down mid-load, then a fresh load.
        set_words();
        start_load();
        repeat (99) tick();
        i_pwr_down = 1'b1;
        tick();
        i_pwr_down = 1'b0;
        check("abort_outs", {busy, done, abort, o_wclk, o_fqud, o_data1, o_data2, o_data3}, 8'b0010_0000);
        tick();
        check("abort_low", abort, 0);
        monitor_load(400, 0);
        check("no_done_after_abort", done_cnt, 0);
        check("no_wclk_after_abort", wrise, 0);
        start_load();
        monitor_load(330, 0);
        check("reload_cap2", cap2, 40'hF8_A5A5_A5A5);
        check("reload_done", done_n, 325);

        // Start while in power-down is ignored.
        i_pwr_down = 1'b1;
        start_load();
        i_pwr_down = 1'b0;
        check("pd_start_busy", busy, 0);
        monitor_load(40, 0);
        check("pd_start_wclk", wrise, 0);
        check("pd_start_abort", abort_cnt, 0);
        check("pd_start_done", done_cnt, 0);

        // Asynchronous reset mid-load, then CLK_DIV=1 timing.
        start_load();
        repeat (199) tick();
        check("busy_before_rst", busy, 1);
        #2 rstn = 1'b0;
        #1;
        check("async_reset_outs", {busy, done, abort, o_wclk, o_fqud, o_data1, o_data2, o_data3}, 0);
        @(negedge clk);
        rstn = 1'b1;
        tick();
        start_load();
        found = 0;
        for (int n = 1; n <= 120; n++) begin
            if (done_f && found == 0) found = n;
            tick();
        end
        check("fast_done_cycle", found, 82);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
